// File: rtl/hd44780_framebuf_if.sv
// Host / display-driver bus for the HD44780 frame buffer.
//
// Signals:
//   wr_valid, wr_data, wr_ready : host byte stream (valid/ready handshake)
//   rd_addr, rd_data            : display-driver read port (combinational)
//   drv_busy, drv_trg           : refresh handshake with the HD44780 driver
//   cursor, dirty               : status, current write position and
//                                 "frame changed since last trigger"
//
// Modports:
//   master : the environment (host + driver) side
//   slave  : the frame buffer side
interface hd44780_framebuf_if #(
  parameter int AW = 7
);
  logic          wr_valid;
  logic [7:0]    wr_data;
  logic          wr_ready;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          drv_busy;
  logic          drv_trg;
  logic [AW-1:0] cursor;
  logic          dirty;

  modport master (
    output wr_valid, wr_data, rd_addr, drv_busy,
    input  wr_ready, rd_data, drv_trg, cursor, dirty
  );

  modport slave (
    input  wr_valid, wr_data, rd_addr, drv_busy,
    output wr_ready, rd_data, drv_trg, cursor, dirty
  );
endinterface

// File: rtl/hd44780_framebuf.sv
// Character frame buffer in front of an HD44780 display driver.
//
// The host streams bytes into a LINE_WIDTH x NUM_LINES buffer at an
// auto-incrementing cursor. Whenever the buffer has changed and the driver
// is idle, a one-cycle drv_trg starts a refresh; host writes are stalled
// until the driver has raised and dropped drv_busy, so the driver always
// reads a frozen frame. If the driver never raises busy within 4 cycles
// the refresh is retried.
//
// Ports:
//   clk : clock, all logic on posedge
//   rst : synchronous active-high reset, restarts the fill (CLEAR) sequence
//   bus : hd44780_framebuf_if.slave (write stream, read port, driver
//         handshake, cursor/dirty status)
//
// Optional feature: define HD44780_FRAMEBUF_CTRL_CODES_EN to interpret
// control bytes (FF clears, CR, LF, BS move the cursor, other non-printable
// bytes are dropped). Without it every accepted byte is stored.
module hd44780_framebuf #(
  parameter int         LINE_WIDTH = 20,
  parameter int         NUM_LINES  = 4,
  parameter logic [7:0] FILL_CHAR  = 8'h20
) (
  input  logic              clk,
  input  logic              rst,
  hd44780_framebuf_if.slave bus
);

  localparam int            DEPTH = LINE_WIDTH * NUM_LINES;
  localparam int            AW    = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

  typedef enum logic [2:0] {
    CLEAR,
    IDLE,
    TRIG,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] clr_cnt;
  logic [AW-1:0] cursor;
  logic          dirty;
  logic [1:0]    to_cnt;

  logic [7:0]    mem [DEPTH];

  logic          ready;
  logic          trg;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;

  logic          accept;
  logic          store;
  logic          go_clear;
  logic [AW-1:0] cursor_inc;

  assign accept     = bus.wr_valid && (state == IDLE);
  assign cursor_inc = (cursor == LAST) ? '0 : cursor + AW'(1);

`ifdef HD44780_FRAMEBUF_CTRL_CODES_EN
  logic          is_print;
  logic          is_cr;
  logic          is_lf;
  logic          is_bs;
  logic [AW-1:0] line_base;
  logic [AW-1:0] next_line;
  logic [AW-1:0] cursor_dec;

  assign is_print = (bus.wr_data >= 8'h20) && (bus.wr_data <= 8'h7E);
  assign go_clear = accept && (bus.wr_data == 8'h0C);
  assign is_cr    = accept && (bus.wr_data == 8'h0D);
  assign is_lf    = accept && (bus.wr_data == 8'h0A);
  assign is_bs    = accept && (bus.wr_data == 8'h08);
  assign store    = accept && is_print;

  // Start address of the cursor's line, found with a comparator chain so no
  // divider is needed for non-power-of-two line widths.
  always_comb begin
    line_base = '0;
    for (int l = 1; l < NUM_LINES; l++) begin
      if (cursor >= AW'(l * LINE_WIDTH)) line_base = AW'(l * LINE_WIDTH);
    end
  end

  assign next_line  = (line_base == AW'((NUM_LINES - 1) * LINE_WIDTH)) ?
                      '0 : line_base + AW'(LINE_WIDTH);
  assign cursor_dec = (cursor == '0) ? LAST : cursor - AW'(1);
`else
  assign go_clear = 1'b0;
  assign store    = accept;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= CLEAR;
    else     state <= state_nxt;
  end

  // Next-state logic; an accepted write wins over starting a refresh.
  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:     if (clr_cnt == LAST) state_nxt = IDLE;
      IDLE: begin
        if (accept) begin
          if (go_clear) state_nxt = CLEAR;
        end else if (dirty && !bus.drv_busy) begin
          state_nxt = TRIG;
        end
      end
      TRIG:      state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (bus.drv_busy)         state_nxt = WAIT_DONE;
        else if (to_cnt == 2'd3) state_nxt = IDLE;
      end
      WAIT_DONE: if (!bus.drv_busy) state_nxt = IDLE;
      default:   state_nxt = CLEAR;
    endcase
  end

  // Outputs and memory write port
  always_comb begin
    ready     = 1'b0;
    trg       = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = clr_cnt;
    mem_wdata = FILL_CHAR;
    case (state)
      CLEAR: mem_we = 1'b1;
      IDLE: begin
        ready = 1'b1;
        if (store) begin
          mem_we    = 1'b1;
          mem_addr  = cursor;
          mem_wdata = bus.wr_data;
        end
      end
      TRIG:    trg = 1'b1;
      default: ;
    endcase
  end

  // Control registers: fill counter, cursor, dirty flag, busy timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_cnt <= '0;
      cursor  <= '0;
      dirty   <= 1'b0;
      to_cnt  <= '0;
    end else begin
      case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + AW'(1);
          if (clr_cnt == LAST) begin
            clr_cnt <= '0;
            cursor  <= '0;
            dirty   <= 1'b1;
          end
        end
        IDLE: begin
          if (store) begin
            cursor <= cursor_inc;
            dirty  <= 1'b1;
          end
`ifdef HD44780_FRAMEBUF_CTRL_CODES_EN
          if (go_clear) begin
            clr_cnt <= '0;
            cursor  <= '0;
          end
          if (is_cr) cursor <= line_base;
          if (is_lf) cursor <= next_line;
          if (is_bs) cursor <= cursor_dec;
`endif
        end
        TRIG: begin
          dirty  <= 1'b0;
          to_cnt <= '0;
        end
        WAIT_BUSY: begin
          to_cnt <= to_cnt + 2'd1;
          // Driver never answered: re-arm so the refresh is retried.
          if (!bus.drv_busy && (to_cnt == 2'd3)) dirty <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Character storage; contents are meaningful only after a full CLEAR.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  // Out-of-range addresses read as zero.
  assign bus.rd_data  = ({1'b0, bus.rd_addr} < (AW + 1)'(DEPTH)) ?
                        mem[bus.rd_addr] : 8'h00;
  assign bus.wr_ready = ready;
  assign bus.drv_trg  = trg;
  assign bus.cursor   = cursor;
  assign bus.dirty    = dirty;

endmodule
